// File: rtl/buf_scanout_if.sv
// rtl/buf_scanout_if.sv - frame buffer read port and display pixel bus for buf_scanout
interface buf_scanout_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] addr_read;
    logic              RE;
    logic [7:0]        din00;
    logic [7:0]        din01;
    logic [7:0]        din02;
    logic [7:0]        pix_b;
    logic [7:0]        pix_g;
    logic [7:0]        pix_r;
    logic              pix_valid;
    logic              hsync;
    logic              vsync;

    modport master (
        output addr_read, RE, pix_b, pix_g, pix_r, pix_valid, hsync, vsync,
        input  din00, din01, din02
    );

    modport slave (
        input  addr_read, RE, pix_b, pix_g, pix_r, pix_valid, hsync, vsync,
        output din00, din01, din02
    );
endinterface

// File: rtl/buf_scanout.sv
// rtl/buf_scanout.sv - raster-order frame buffer scan-out with latency-aligned syncs
module buf_scanout #(
    parameter int H_ACTIVE = 10,
    parameter int V_ACTIVE = 10,
    parameter int H_BLANK  = 2,
    parameter int V_BLANK  = 1,
    parameter int ADDR_W   = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    buf_scanout_if.master bus,
    output logic          frame_done,
    output logic          busy
);
    localparam int VB_LEN  = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int CNT_MAX = (VB_LEN > H_ACTIVE) ? ((VB_LEN > H_BLANK) ? VB_LEN : H_BLANK)
                                                 : ((H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int VCNT_W  = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t              state;
    logic [CNT_W-1:0]    hcnt;
    logic [VCNT_W-1:0]   vcnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                re_q;

    logic                re_d1;
    logic                hb_d1;
    logic                vb_d1;
    logic [7:0]          pix_b_q;
    logic [7:0]          pix_g_q;
    logic [7:0]          pix_r_q;
    logic                pix_valid_q;
    logic                hsync_q;
    logic                vsync_q;
    logic                frame_done_q;

    // Raster walker: the address is a running counter that only moves on pixel
    // cycles, so it holds through blanking and tops out at the last pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            hcnt   <= '0;
            vcnt   <= '0;
            addr_q <= '0;
            re_q   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= ACTIVE;
                        hcnt   <= '0;
                        vcnt   <= '0;
                        addr_q <= '0;
                        re_q   <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (hcnt == CNT_W'(H_ACTIVE - 1)) begin
                        state <= HBLANK;
                        hcnt  <= '0;
                        re_q  <= 1'b0;
                    end else begin
                        hcnt   <= hcnt + CNT_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                HBLANK: begin
                    if (hcnt == CNT_W'(H_BLANK - 1)) begin
                        hcnt <= '0;
                        if (vcnt < VCNT_W'(V_ACTIVE - 1)) begin
                            state  <= ACTIVE;
                            vcnt   <= vcnt + VCNT_W'(1);
                            addr_q <= addr_q + ADDR_W'(1);
                            re_q   <= 1'b1;
                        end else begin
                            state <= VBLANK;
                        end
                    end else begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end
                VBLANK: begin
                    if (hcnt == CNT_W'(VB_LEN - 1)) begin
                        hcnt <= '0;
                        vcnt <= '0;
                        if (enable) begin
                            state  <= ACTIVE;
                            addr_q <= '0;
                            re_q   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    re_q  <= 1'b0;
                end
            endcase

            // busy covers the frame until its done pulse has left the pipeline
            if (state == IDLE && enable)
                busy <= 1'b1;
            else if (frame_done_q && state == IDLE)
                busy <= 1'b0;
        end
    end

    // Two-stage alignment: stage 1 matches the buffer's registered read,
    // stage 2 captures the read data; syncs ride the same two stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            re_d1        <= 1'b0;
            hb_d1        <= 1'b0;
            vb_d1        <= 1'b0;
            pix_b_q      <= '0;
            pix_g_q      <= '0;
            pix_r_q      <= '0;
            pix_valid_q  <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            re_d1       <= re_q;
            hb_d1       <= (state == HBLANK);
            vb_d1       <= (state == VBLANK);
            pix_valid_q <= re_d1;
            hsync_q     <= hb_d1;
            vsync_q     <= vb_d1;
            if (re_d1) begin
                pix_b_q <= bus.din00;
                pix_g_q <= bus.din01;
                pix_r_q <= bus.din02;
            end else begin
                pix_b_q <= '0;
                pix_g_q <= '0;
                pix_r_q <= '0;
            end
            // high in the last cycle of the delayed vsync window
            frame_done_q <= vb_d1 && (state != VBLANK);
        end
    end

    assign bus.addr_read = addr_q;
    assign bus.RE        = re_q;
    assign bus.pix_b     = pix_b_q;
    assign bus.pix_g     = pix_g_q;
    assign bus.pix_r     = pix_r_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_buf_scanout.sv
// tb/tb_buf_scanout.sv - randomized self-checking bench for buf_scanout
module tb_buf_scanout;
    localparam int H_ACTIVE = 10;
    localparam int V_ACTIVE = 10;
    localparam int H_BLANK  = 2;
    localparam int V_BLANK  = 1;
    localparam int ADDR_W   = 20;
    localparam int HT       = H_ACTIVE + H_BLANK;
    localparam int FRAME    = (V_ACTIVE + V_BLANK) * HT;
    localparam int NPIX     = H_ACTIVE * V_ACTIVE;

    logic clock;
    logic reset;
    logic enable;
    logic frame_done;
    logic busy;

    buf_scanout_if #(.ADDR_W(ADDR_W)) bus ();

    buf_scanout #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .V_BLANK(V_BLANK), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus),
        .frame_done(frame_done), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [23:0] mem [0:NPIX-1];

    // frame buffer: registered read, word = {red, green, blue}
    always @(posedge clock) begin
        if (bus.RE && bus.addr_read < ADDR_W'(NPIX))
            {bus.din02, bus.din01, bus.din00} <= mem[bus.addr_read];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: frame position k in 0..FRAME-1 decoded to line/column
    typedef struct packed {
        logic        fr;
        logic        re;
        logic        hb;
        logic        vb;
        logic        last;
        logic [19:0] addr;
        logic [23:0] word;
    } info_t;

    function automatic info_t info_of(input bit run, input int kk);
        info_t i;
        int line, col;
        i = '0;
        if (run) begin
            line   = kk / HT;
            col    = kk % HT;
            i.fr   = 1'b1;
            i.re   = (line < V_ACTIVE) && (col < H_ACTIVE);
            i.hb   = (line < V_ACTIVE) && (col >= H_ACTIVE);
            i.vb   = (line >= V_ACTIVE);
            i.last = (kk == FRAME - 1);
            if (i.re) begin
                i.addr = 20'(line * H_ACTIVE + col);
                i.word = mem[line * H_ACTIVE + col];
            end
        end
        return i;
    endfunction

    bit    running = 0;
    int    k = 0;
    int    model_addr = 0;
    info_t hist [3];

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        hist[2] = '0;
    end

    always @(posedge clock) begin
        if (reset) begin
            running    = 0;
            k          = 0;
            model_addr = 0;
            hist[0]    = '0;
            hist[1]    = '0;
            hist[2]    = '0;
        end else begin
            if (!running) begin
                if (enable) begin
                    running = 1;
                    k = 0;
                end
            end else if (k == FRAME - 1) begin
                if (enable) k = 0;
                else running = 0;
            end else begin
                k++;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = info_of(running, k);
            if (hist[0].re) model_addr = int'(hist[0].addr);
        end
    end

    bit chk_en = 0;
    int n_pix = 0;
    int n_fd = 0;
    int max_addr = 0;

    always @(negedge clock) begin
        if (chk_en) begin
            chk("re",         32'(bus.RE),        32'(hist[0].re));
            chk("addr_read",  32'(bus.addr_read), 32'(model_addr));
            chk("pix_valid",  32'(bus.pix_valid), 32'(hist[2].re));
            chk("pix_rgb",    32'({bus.pix_r, bus.pix_g, bus.pix_b}), 32'(hist[2].word));
            chk("hsync",      32'(bus.hsync),     32'(hist[2].hb));
            chk("vsync",      32'(bus.vsync),     32'(hist[2].vb));
            chk("frame_done", 32'(frame_done),    32'(hist[2].last));
            chk("busy",       32'(busy),          32'(running || hist[1].fr || hist[2].fr));
            if (bus.pix_valid) n_pix++;
            if (frame_done) n_fd++;
            if (int'(bus.addr_read) > max_addr) max_addr = int'(bus.addr_read);
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!busy && !bus.RE) break;
            @(negedge clock);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    int p0, f0;

    initial begin
        for (int a = 0; a < NPIX; a++)
            mem[a] = {8'(a), 8'(a + 1), 8'(a + 2)};
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        chk_en = 1;
        repeat (2) @(negedge clock);
        chk("rst_addr", 32'(bus.addr_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // three back-to-back frames
        reset = 1'b0;
        p0 = n_pix; f0 = n_fd;
        enable = 1'b1;
        repeat (3 * FRAME - 5) @(negedge clock);
        enable = 1'b0;
        wait_idle("idle_after_3f");
        repeat (3) @(negedge clock);
        chk("pix_3f", 32'(n_pix - p0), 32'(3 * NPIX));
        chk("fd_3f",  32'(n_fd - f0), 32'd3);
        chk("max_addr_ok", 32'(max_addr <= NPIX - 1), 32'd1);

        // enable dropped around pixel 45: frame still completes
        p0 = n_pix; f0 = n_fd;
        enable = 1'b1;
        repeat (1 + 4 * HT + 5) @(negedge clock);
        enable = 1'b0;
        wait_idle("idle_after_drop");
        repeat (3) @(negedge clock);
        chk("pix_drop", 32'(n_pix - p0), 32'(NPIX));
        chk("fd_drop",  32'(n_fd - f0), 32'd1);
        chk("re_drop",  32'(bus.RE), 32'd0);

        // reset around pixel 37 aborts with no frame_done
        p0 = n_pix; f0 = n_fd;
        enable = 1'b1;
        repeat (1 + 3 * HT + 7) @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_valid", 32'(bus.pix_valid), 32'd0);
        chk("abort_addr",  32'(bus.addr_read), 32'd0);
        repeat (FRAME) @(negedge clock);
        chk("abort_fd",   32'(n_fd - f0), 32'd0);
        chk("abort_pix",  32'(n_pix - p0 < NPIX), 32'd1);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        chk("restart_addr", 32'(bus.addr_read), 32'd0);
        chk("restart_re",   32'(bus.RE), 32'd1);
        wait_idle("idle_after_restart");

        // random data, random enable and occasional reset
        for (int a = 0; a < NPIX; a++)
            mem[a] = 24'($urandom);
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 99) < 85);
            reset  = ($urandom_range(0, 599) == 0);
            @(negedge clock);
        end
        reset  = 1'b0;
        enable = 1'b0;
        wait_idle("idle_final");
        chk("max_addr_final", 32'(max_addr <= NPIX - 1), 32'd1);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/buf_scanout.md
Name: buf_scanout

Overview:
Scan-out reader for the display frame buffer. It walks the buffer in raster order, driving the buffer's read address and read enable. It absorbs the buffer's one-cycle registered read latency and presents aligned RGB pixels with hsync/vsync/valid to the display output stage. The frame buffer's host-side write port is not touched by this block.

Parameters:
H_ACTIVE, 10, visible pixels per line (100 for the full-size build).
V_ACTIVE, 10, visible lines per frame (100 for the full-size build).
H_BLANK, 2, blank cycles appended to each line (hsync window).
V_BLANK, 1, blank lines appended to each frame (vsync window).
ADDR_W, 20, buffer read address width.

Ports:
clock  input  1  single clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
enable  input  1  start/continue scanning frames.
addr_read  output  ADDR_W  buffer read address.
RE  output  1  buffer read enable.
din00  input  8  buffer read data, blue (bits 7:0 of word).
din01  input  8  buffer read data, green (bits 15:8).
din02  input  8  buffer read data, red (bits 23:16).
pix_b, pix_g, pix_r  output  8 each  pixel to display.
pix_valid  output  1  pixel outputs carry an active pixel.
hsync  output  1  high during horizontal blank.
vsync  output  1  high during vertical blank lines.
frame_done  output  1  one-cycle pulse after the last pixel of a frame is output.
busy  output  1  high from frame start until the frame completes.

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset: state=IDLE; hcnt=vcnt=0; addr_read=0; RE=0; pix_*=0; pix_valid=0; hsync=0; vsync=0; frame_done=0; busy=0. Reset applied mid-frame aborts the frame immediately, with no frame_done.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE -> ACTIVE when enable=1. Counters and address are zeroed on entry.
- ACTIVE: RE=1; addr_read=running address; hcnt increments each cycle, and the address increments with it.
  - At hcnt=H_ACTIVE-1: go to HBLANK, hcnt=0.
- HBLANK: RE=0; lasts H_BLANK cycles.
  - Exit goes to ACTIVE with vcnt+1 if vcnt<V_ACTIVE-1.
  - Otherwise exit goes to VBLANK.
- VBLANK: RE=0; lasts V_BLANK*(H_ACTIVE+H_BLANK) cycles.
  - Exit goes to ACTIVE (new frame, address 0) if enable=1, else to IDLE.
- Frame period: (V_ACTIVE+V_BLANK)*(H_ACTIVE+H_BLANK) cycles. For the defaults this is 132.
- Address: a counter, not a multiply. It is held during blank and is never reset except at frame start.
  - Max address is H_ACTIVE*V_ACTIVE-1 (99 for the defaults); it never exceeds this.
- Read latency: the buffer registers data on the posedge that samples RE.
  - The block samples din in the cycle after RE and registers the pixel outputs.
  - RE at cycle t gives pix_* and pix_valid=1 at cycle t+2.
- Sync alignment: hsync and vsync are generated from FSM state and delayed by the same 2 stages, so they stay aligned with the pixel stream.
  - hsync=1 for H_BLANK cycles after each active line's last pixel.
  - vsync=1 for the whole VBLANK window; hsync stays 0 during vsync.
- Idle outputs: pix_* are forced to 0 whenever pix_valid=0.
- enable deasserted mid-frame: the current frame completes; the block then goes to IDLE. enable has no effect during a frame.
- frame_done: pulses in the cycle the delayed VBLANK window ends.
- busy: 1 from leaving IDLE until frame_done. busy stays 1 across back-to-back frames.

Test Plan:
- Reset, then enable=1 at cycle 0 -> RE=1 with addr_read=0..9 in cycles 1..10; RE=0 for 2 cycles; next line addr_read=10..19.
- Buffer model preloaded with word[a]={a,a+1,a+2} -> pix_r=a, pix_g=a+1, pix_b=a+2 with pix_valid exactly 2 cycles after the RE for address a. Covers all 100 addresses in order, with no duplicates or skips.
- Full frame with defaults -> 100 pix_valid cycles, 10 hsync pulses of 2 cycles, one vsync window of 12 cycles, frame_done once, frame period 132 cycles; addr_read never exceeds 99.
- enable held high for 3 frames -> addr_read wraps 99->0 at each frame start, busy stays 1, frame_done pulses every 132 cycles.
- enable dropped at pixel 45 -> frame completes (100 pixels), then IDLE with RE=0 and busy=0.
- reset asserted at pixel 37 -> next cycle all outputs 0 and state IDLE, with no frame_done. A new enable restarts at addr_read=0.
